// File: rtl/is2vid_mode_scheduler.sv
// IS2Vid mode scheduler: assembles control-packet fields, scans the mode bank (entry k decided k+2 cycles after hdr_done),
// and switches the timing generator at a frame boundary via req/ack; header strobes while busy are dropped with a pulse.
module is2vid_mode_scheduler #(
  parameter int NUM_MODES   = 4,
  parameter int WIDTH_BITS  = 16,
  parameter int HEIGHT_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hdr_valid,
  input  logic [3:0]                       hdr_sel,
  input  logic [3:0]                       hdr_data,
  input  logic                             hdr_done,
  input  logic [NUM_MODES*WIDTH_BITS-1:0]  mode_width,
  input  logic [NUM_MODES*HEIGHT_BITS-1:0] mode_height,
  input  logic [NUM_MODES-1:0]             mode_interlaced,
  input  logic [NUM_MODES-1:0]             mode_enable,
  input  logic                             tg_frame_end,
  input  logic                             tg_ack,
  output logic                             tg_change_req,
  output logic [3:0]                       tg_mode_idx,
  output logic                             mode_match,
  output logic                             no_match,
  output logic                             hdr_error,
  output logic                             hdr_drop,
  output logic                             busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_WAIT    = 3'd2,
    S_REQ     = 3'd3,
    S_MATCHED = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_MODES - 1);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_idx, w_idx_nx;
  logic [3:0]  r_mode_idx, w_mode_idx_nx;
  logic        r_active_valid, w_active_valid_nx;
  logic        r_no_match, w_no_match_nx;
  logic        r_hdr_error, w_hdr_error_nx;
  logic        r_hdr_drop;
  logic [15:0] r_hdr_w, w_hdr_w_nx;
  logic [15:0] r_hdr_h, w_hdr_h_nx;
  logic        r_ilace, w_ilace_nx;
  logic [8:0]  r_mask, w_mask_nx;
  logic        w_open;
  logic        w_busy;
  logic [15:0] w_hit;
  logic        w_cur_hit;

  assign w_open = (r_state == S_IDLE) || (r_state == S_MATCHED);
  assign w_busy = (r_state == S_SCAN) || (r_state == S_WAIT) || (r_state == S_REQ);

  // Capture path; the next mask is what hdr_done evaluates, so a coincident nibble counts.
  always_comb begin
    w_hdr_w_nx = r_hdr_w;
    w_hdr_h_nx = r_hdr_h;
    w_ilace_nx = r_ilace;
    w_mask_nx  = r_mask;
    if (w_open && hdr_valid) begin
      case (hdr_sel)
        4'd0: begin w_hdr_w_nx[15:12] = hdr_data; w_mask_nx = 9'b0_0000_0001; end
        4'd1: begin w_hdr_w_nx[11:8]  = hdr_data; w_mask_nx[1] = 1'b1; end
        4'd2: begin w_hdr_w_nx[7:4]   = hdr_data; w_mask_nx[2] = 1'b1; end
        4'd3: begin w_hdr_w_nx[3:0]   = hdr_data; w_mask_nx[3] = 1'b1; end
        4'd4: begin w_hdr_h_nx[15:12] = hdr_data; w_mask_nx[4] = 1'b1; end
        4'd5: begin w_hdr_h_nx[11:8]  = hdr_data; w_mask_nx[5] = 1'b1; end
        4'd6: begin w_hdr_h_nx[7:4]   = hdr_data; w_mask_nx[6] = 1'b1; end
        4'd7: begin w_hdr_h_nx[3:0]   = hdr_data; w_mask_nx[7] = 1'b1; end
        4'd8: begin w_ilace_nx        = hdr_data[3]; w_mask_nx[8] = 1'b1; end
        default: ;
      endcase
    end
  end

  // Per-entry match vector padded to 16 so the 4-bit scan index selects cleanly.
  for (genvar k = 0; k < 16; k++) begin : g_hit
    if (k < NUM_MODES) begin : g_ent
      assign w_hit[k] = mode_enable[k] &&
                        (mode_width[k*WIDTH_BITS +: WIDTH_BITS] == r_hdr_w[WIDTH_BITS-1:0]) &&
                        (mode_height[k*HEIGHT_BITS +: HEIGHT_BITS] == r_hdr_h[HEIGHT_BITS-1:0]) &&
                        (mode_interlaced[k] == r_ilace);
    end else begin : g_pad
      assign w_hit[k] = 1'b0;
    end
  end
  assign w_cur_hit = w_hit[r_idx];

  always_comb begin
    w_state_nx        = r_state;
    w_idx_nx          = r_idx;
    w_mode_idx_nx     = r_mode_idx;
    w_active_valid_nx = r_active_valid;
    w_no_match_nx     = 1'b0;
    w_hdr_error_nx    = 1'b0;
    case (r_state)
      S_IDLE, S_MATCHED: begin
        if (hdr_done) begin
          if (&w_mask_nx) begin
            w_state_nx = S_SCAN;
            w_idx_nx   = 4'd0;
          end else begin
            w_hdr_error_nx = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (w_cur_hit) begin
          if ((r_idx == r_mode_idx) && r_active_valid) begin
            w_state_nx = S_MATCHED;
          end else begin
            w_state_nx    = S_WAIT;
            w_mode_idx_nx = r_idx;
          end
        end else if (r_idx == LAST_IDX) begin
          w_state_nx    = S_IDLE;
          w_no_match_nx = 1'b1;
        end else begin
          w_idx_nx = r_idx + 4'd1;
        end
      end
      S_WAIT: begin
        if (tg_frame_end) w_state_nx = S_REQ;
      end
      S_REQ: begin
        if (tg_ack) begin
          w_state_nx        = S_MATCHED;
          w_active_valid_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= 4'd0;
      r_mode_idx     <= 4'd0;
      r_active_valid <= 1'b0;
      r_no_match     <= 1'b0;
      r_hdr_error    <= 1'b0;
      r_hdr_drop     <= 1'b0;
      r_hdr_w        <= 16'd0;
      r_hdr_h        <= 16'd0;
      r_ilace        <= 1'b0;
      r_mask         <= 9'd0;
    end else begin
      r_state        <= w_state_nx;
      r_idx          <= w_idx_nx;
      r_mode_idx     <= w_mode_idx_nx;
      r_active_valid <= w_active_valid_nx;
      r_no_match     <= w_no_match_nx;
      r_hdr_error    <= w_hdr_error_nx;
      r_hdr_drop     <= w_busy && (hdr_valid || hdr_done);
      r_hdr_w        <= w_hdr_w_nx;
      r_hdr_h        <= w_hdr_h_nx;
      r_ilace        <= w_ilace_nx;
      r_mask         <= w_mask_nx;
    end
  end

  // Request decoded from state so an async reset removes it without waiting for a clock.
  assign tg_change_req = (r_state == S_REQ);
  assign tg_mode_idx   = r_mode_idx;
  assign mode_match    = (r_state == S_MATCHED);
  assign no_match      = r_no_match;
  assign hdr_error     = r_hdr_error;
  assign hdr_drop      = r_hdr_drop;
  assign busy          = w_busy;

endmodule

// File: tb/tb_is2vid_mode_scheduler.sv
// Directed bench for is2vid_mode_scheduler: vector table of headers plus hand sequences for handshake corners.
module tb_is2vid_mode_scheduler;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst;
  logic hdr_valid, hdr_done;
  logic [3:0] hdr_sel, hdr_data;
  logic [15:0] bw[NM];
  logic [15:0] bh[NM];
  logic [NM-1:0] bil, ben;
  logic [NM*16-1:0] mode_width, mode_height;
  logic tg_frame_end, tg_ack;
  logic tg_change_req, mode_match, no_match, hdr_error, hdr_drop, busy;
  logic [3:0] tg_mode_idx;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mode_width  = {bw[3], bw[2], bw[1], bw[0]};
  assign mode_height = {bh[3], bh[2], bh[1], bh[0]};

  is2vid_mode_scheduler #(.NUM_MODES(NM), .WIDTH_BITS(16), .HEIGHT_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_sel(hdr_sel), .hdr_data(hdr_data), .hdr_done(hdr_done),
    .mode_width(mode_width), .mode_height(mode_height),
    .mode_interlaced(bil), .mode_enable(ben),
    .tg_frame_end(tg_frame_end), .tg_ack(tg_ack),
    .tg_change_req(tg_change_req), .tg_mode_idx(tg_mode_idx),
    .mode_match(mode_match), .no_match(no_match),
    .hdr_error(hdr_error), .hdr_drop(hdr_drop), .busy(busy)
  );

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic        il;
    logic [3:0]  en;
    logic        hit;
    int          idx;
    logic        cat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] sel, input logic [3:0] data, input logic done);
    hdr_valid = 1'b1; hdr_sel = sel; hdr_data = data; hdr_done = done;
    cyc();
    hdr_valid = 1'b0; hdr_done = 1'b0;
  endtask

  // Returns one negedge after the hdr_done cycle (observation of T+1).
  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h, input logic il, input logic cat);
    for (int i = 0; i < 4; i++) send_nib(4'(i), w[15-4*i -: 4], 1'b0);
    for (int i = 0; i < 4; i++) send_nib(4'(i+4), h[15-4*i -: 4], 1'b0);
    if (cat) begin
      send_nib(4'd8, {il, 3'b000}, 1'b1);
    end else begin
      send_nib(4'd8, {il, 3'b000}, 1'b0);
      hdr_done = 1'b1; cyc(); hdr_done = 1'b0;
    end
  endtask

  task automatic pulse_fe();
    tg_frame_end = 1'b1; cyc(); tg_frame_end = 1'b0;
  endtask

  task automatic pulse_ack();
    tg_ack = 1'b1; cyc(); tg_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic bank_default();
    bw[0] = 16'd1280; bh[0] = 16'd720;
    bw[1] = 16'd1920; bh[1] = 16'd1080;
    bw[2] = 16'd1920; bh[2] = 16'd1080;
    bw[3] = 16'd640;  bh[3] = 16'd480;
    bil = 4'b0010;
    ben = 4'b1111;
  endtask

  // Reset, then lock onto 1920x1080p (entry 2) through the full handshake.
  task automatic match2();
    do_reset();
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b0);
    repeat (4) cyc();
    pulse_fe();
    pulse_ack();
    chk("match2_mm", 32'(mode_match), 1);
  endtask

  vec_t v[8];

  initial begin
    rst = 1'b1; hdr_valid = 1'b0; hdr_done = 1'b0; hdr_sel = 4'd0; hdr_data = 4'd0;
    tg_frame_end = 1'b0; tg_ack = 1'b0;
    bank_default();

    v[0] = '{16'd1920, 16'd1080, 1'b0, 4'b1111, 1'b1, 2, 1'b0};
    v[1] = '{16'd1920, 16'd1080, 1'b1, 4'b1111, 1'b1, 1, 1'b1};
    v[2] = '{16'd1280, 16'd720,  1'b0, 4'b1111, 1'b1, 0, 1'b0};
    v[3] = '{16'd640,  16'd480,  1'b0, 4'b0111, 1'b0, 0, 1'b1};
    v[4] = '{16'd640,  16'd480,  1'b0, 4'b1000, 1'b1, 3, 1'b0};
    v[5] = '{16'd1920, 16'd1080, 1'b0, 4'b1011, 1'b0, 0, 1'b0};
    v[6] = '{16'd1280, 16'd721,  1'b0, 4'b1111, 1'b0, 0, 1'b1};
    v[7] = '{16'd1920, 16'd1080, 1'b1, 4'b1101, 1'b0, 0, 1'b0};

    #1;
    chk("rst_req",  32'(tg_change_req), 0);
    chk("rst_idx",  32'(tg_mode_idx), 0);
    chk("rst_mm",   32'(mode_match), 0);
    chk("rst_nm",   32'(no_match), 0);
    chk("rst_err",  32'(hdr_error), 0);
    chk("rst_drop", 32'(hdr_drop), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      do_reset();
      ben = v[n].en;
      send_hdr(v[n].w, v[n].h, v[n].il, v[n].cat);
      chk("vec_scan_busy", 32'(busy), 1);
      chk("vec_scan_mm", 32'(mode_match), 0);
      if (v[n].hit) begin
        repeat (v[n].idx + 1) cyc();
        chk("vec_wait_idx", 32'(tg_mode_idx), 32'(v[n].idx));
        chk("vec_wait_busy", 32'(busy), 1);
        chk("vec_wait_nm", 32'(no_match), 0);
        cyc();
        chk("vec_wait_req", 32'(tg_change_req), 0);
        pulse_fe();
        chk("vec_req", 32'(tg_change_req), 1);
        chk("vec_req_idx", 32'(tg_mode_idx), 32'(v[n].idx));
        pulse_ack();
        chk("vec_mm", 32'(mode_match), 1);
        chk("vec_req_low", 32'(tg_change_req), 0);
        chk("vec_idle_busy", 32'(busy), 0);
      end else begin
        repeat (3) cyc();
        chk("vec_nm_early", 32'(no_match), 0);
        chk("vec_nm_busy", 32'(busy), 1);
        cyc();
        chk("vec_nm_pulse", 32'(no_match), 1);
        chk("vec_nm_idle", 32'(busy), 0);
        chk("vec_nm_mm", 32'(mode_match), 0);
        cyc();
        chk("vec_nm_end", 32'(no_match), 0);
      end
    end
    ben = 4'b1111;

    // Same header while matched on the active mode: no handshake, matched at T+4.
    match2();
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      chk("rematch_req", 32'(tg_change_req), 0);
      chk("rematch_mm", 32'(mode_match), (j == 4) ? 1 : 0);
      if (j < 4) cyc();
    end

    // frame_end held during the whole scan, including the hit cycle, is not counted.
    do_reset();
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b0);
    tg_frame_end = 1'b1;
    repeat (3) cyc();
    tg_frame_end = 1'b0;
    chk("fe_scan_idx", 32'(tg_mode_idx), 2);
    chk("fe_scan_req", 32'(tg_change_req), 0);
    cyc();
    chk("fe_scan_req2", 32'(tg_change_req), 0);
    pulse_fe();
    chk("fe_req", 32'(tg_change_req), 1);
    pulse_ack();
    chk("fe_mm", 32'(mode_match), 1);

    // Two matching entries: lowest wins; then disable it and switch to the other.
    do_reset();
    bw[3] = 16'd1920; bh[3] = 16'd1080; bil[3] = 1'b1;
    send_hdr(16'd1920, 16'd1080, 1'b1, 1'b0);
    repeat (2) cyc();
    chk("multi_idx", 32'(tg_mode_idx), 1);
    cyc();
    pulse_fe();
    pulse_ack();
    chk("multi_mm", 32'(mode_match), 1);
    ben[1] = 1'b0;
    send_hdr(16'd1920, 16'd1080, 1'b1, 1'b1);
    repeat (3) cyc();
    chk("multi2_idx_early", 32'(tg_mode_idx), 1);
    cyc();
    chk("multi2_idx", 32'(tg_mode_idx), 3);
    chk("multi2_mm", 32'(mode_match), 0);
    cyc();
    pulse_fe();
    chk("multi2_req", 32'(tg_change_req), 1);
    chk("multi2_req_idx", 32'(tg_mode_idx), 3);
    pulse_ack();
    chk("multi2_mm_end", 32'(mode_match), 1);
    bank_default();

    // Incomplete header from IDLE.
    do_reset();
    for (int i = 0; i < 8; i++) send_nib(4'(i), 4'(i), 1'b0);
    hdr_done = 1'b1; cyc(); hdr_done = 1'b0;
    chk("err_pulse", 32'(hdr_error), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_nm", 32'(no_match), 0);
    cyc();
    chk("err_end", 32'(hdr_error), 0);
    chk("err_noscan", 32'(busy), 0);

    // sel 0 with hdr_done in MATCHED restarts the mask: error, match retained.
    match2();
    send_nib(4'd0, 4'd0, 1'b1);
    chk("err_m_pulse", 32'(hdr_error), 1);
    chk("err_m_mm", 32'(mode_match), 1);
    chk("err_m_busy", 32'(busy), 0);

    // Strobes while busy are dropped and leave fields/mask untouched.
    do_reset();
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b0);
    hdr_done = 1'b1; cyc(); hdr_done = 1'b0;
    chk("drop_scan", 32'(hdr_drop), 1);
    repeat (2) cyc();
    chk("drop_wait_idx", 32'(tg_mode_idx), 2);
    send_nib(4'd0, 4'hF, 1'b0);
    chk("drop_wait", 32'(hdr_drop), 1);
    chk("drop_wait_busy", 32'(busy), 1);
    cyc();
    chk("drop_end", 32'(hdr_drop), 0);
    pulse_fe();
    pulse_ack();
    chk("drop_mm", 32'(mode_match), 1);
    hdr_done = 1'b1; cyc(); hdr_done = 1'b0;
    chk("drop_fields_err", 32'(hdr_error), 0);
    chk("drop_fields_busy", 32'(busy), 1);
    repeat (3) cyc();
    chk("drop_fields_mm", 32'(mode_match), 1);
    chk("drop_fields_req", 32'(tg_change_req), 0);

    // Async reset mid-handshake, then full handshake required for the same index.
    do_reset();
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b0);
    repeat (4) cyc();
    pulse_fe();
    chk("arst_pre_req", 32'(tg_change_req), 1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(tg_change_req), 0);
    chk("arst_idx", 32'(tg_mode_idx), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mm", 32'(mode_match), 0);
    cyc();
    rst = 1'b0;
    send_hdr(16'd1920, 16'd1080, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("arst_wait_idx", 32'(tg_mode_idx), 2);
    chk("arst_wait_mm", 32'(mode_match), 0);
    chk("arst_wait_busy", 32'(busy), 1);
    cyc();
    pulse_fe();
    chk("arst_req2", 32'(tg_change_req), 1);
    pulse_ack();
    chk("arst_mm2", 32'(mode_match), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
